speech_source_gen: RTL and testbench

Parametrised excitation source for the speech synthesiser: generates one signed sample per rising edge of the sample strobe (10 kHz), selectable between glottal pulse train, LFSR noise, mixed voiced+noise, and silence. Period, mode and amplitude are latched only at period boundaries, so frame updates never produce truncated pulses. Output feeds the lattice/filter stage; `period_done` tells the frame controller when to load the next parameters.

---
 rtl/speech_source_gen_pkg.sv | 17 +
 rtl/speech_lfsr17.sv | 27 ++
 rtl/speech_source_gen.sv | 141 ++++++++++++++
 tb/tb_speech_source_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/speech_source_gen_pkg.sv
// Shared constants for the speech excitation source.
//   MODE_*      : excitation mode encodings
//   LFSR_SEED   : reset/seed value of the 17-bit noise LFSR
//   LFSR_TAP_*  : feedback taps for x^17 + x^3 + 1
package speech_pkg;

  localparam logic [1:0] MODE_PULSE  = 2'd0;
  localparam logic [1:0] MODE_NOISE  = 2'd1;
  localparam logic [1:0] MODE_MIXED  = 2'd2;
  localparam logic [1:0] MODE_SILENT = 2'd3;

  localparam logic [16:0] LFSR_SEED = 17'h1;

  localparam int unsigned LFSR_TAP_HI = 16;
  localparam int unsigned LFSR_TAP_LO = 2;

endpackage

// File: rtl/speech_lfsr17.sv
// 17-bit Fibonacci LFSR (x^17 + x^3 + 1), reusable noise source.
//   clk, rst_an : clock, async active-low reset (reseeds)
//   advance     : shift one step this clock
//   state       : current register contents
//   new_bit_c   : bit that enters position 0 on the next advance
module speech_lfsr17
  import speech_pkg::*;
(
  input  logic        clk,
  input  logic        rst_an,
  input  logic        advance,
  output logic [16:0] state,
  output logic        new_bit_c
);

  assign new_bit_c = state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO];

  // Shift register with feedback into bit 0.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= {state[15:0], new_bit_c};
    end
  end

endmodule

// File: rtl/speech_source_gen.sv
// Excitation source: one signed sample per rising strobe edge, selectable
// pulse / noise / mixed / silent; parameters latched at period boundaries.
//   clk, rst_an  : clock, async active-low reset
//   strobe       : sample request (rising edge, clk domain)
//   period       : pitch period in samples, 0 forces noise
//   amplitude    : unsigned magnitude
//   mode         : excitation mode (see speech_pkg)
//   period_done  : pulses with the last sample of a period
//   out_valid    : pulses when source_out updates
//   source_out   : signed sample
module speech_source_gen
  import speech_pkg::*;
#(
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned PERIOD_W    = 8,
  parameter int unsigned PULSE_LEN   = 8,
  parameter int unsigned NOISE_FRAME = 64,
  parameter int unsigned MIX_SHIFT   = 2
) (
  input  logic                clk,
  input  logic                rst_an,
  input  logic                strobe,
  input  logic [PERIOD_W-1:0] period,
  input  logic [OUT_W-2:0]    amplitude,
  input  logic [1:0]          mode,
  output logic                period_done,
  output logic                out_valid,
  output logic [OUT_W-1:0]    source_out
);

  localparam int unsigned NF_W  = $clog2(NOISE_FRAME);
  localparam int unsigned CNT_W = (PERIOD_W > NF_W) ? PERIOD_W : NF_W;
  localparam int unsigned SUM_W = OUT_W + 1;

  logic                strobe_d, strobe_d_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [PERIOD_W-1:0] p_q, p_n;
  logic [1:0]          m_q, m_n;
  logic [OUT_W-2:0]    a_q, a_n;
  logic                period_done_n, out_valid_n;
  logic [OUT_W-1:0]    source_out_n;

  logic                sample_c;
  logic                noise_bit_c;
  logic [16:0]         lfsr_state_unused;

  speech_lfsr17 u_lfsr (
    .clk       (clk),
    .rst_an    (rst_an),
    .advance   (sample_c),
    .state     (lfsr_state_unused),
    .new_bit_c (noise_bit_c)
  );

  // State registers.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      strobe_d    <= 1'b0;
      cnt         <= '0;
      p_q         <= '0;
      m_q         <= '0;
      a_q         <= '0;
      period_done <= 1'b1;
      out_valid   <= 1'b0;
      source_out  <= '0;
    end else begin
      strobe_d    <= strobe_d_n;
      cnt         <= cnt_n;
      p_q         <= p_n;
      m_q         <= m_n;
      a_q         <= a_n;
      period_done <= period_done_n;
      out_valid   <= out_valid_n;
      source_out  <= source_out_n;
    end
  end

  logic                boundary;
  logic [PERIOD_W-1:0] p_eff;
  logic [1:0]          m_eff;
  logic [OUT_W-2:0]    a_eff;
  logic                noise_len;
  logic [CNT_W-1:0]    last_idx;
  logic [SUM_W-1:0]    a_ext, pulse_val, noise_val, mix_mag, mix_term, mix_sum;
  logic [OUT_W-1:0]    mix_sat;

  assign sample_c = strobe & ~strobe_d;

  // Next-state and sample computation; on a boundary sample the fresh
  // inputs are used directly so the new frame starts on this sample.
  always_comb begin
    strobe_d_n    = strobe;
    cnt_n         = cnt;
    p_n           = p_q;
    m_n           = m_q;
    a_n           = a_q;
    period_done_n = 1'b0;
    out_valid_n   = 1'b0;
    source_out_n  = source_out;

    boundary  = (cnt == '0);
    p_eff     = boundary ? period    : p_q;
    m_eff     = boundary ? mode      : m_q;
    a_eff     = boundary ? amplitude : a_q;

    noise_len = (m_eff == MODE_NOISE) || (p_eff == '0);
    last_idx  = noise_len ? CNT_W'(NOISE_FRAME - 1) : (CNT_W'(p_eff) - CNT_W'(1));

    a_ext     = SUM_W'(a_eff);
    pulse_val = (32'(cnt) < PULSE_LEN) ? a_ext : '0;
    noise_val = noise_bit_c ? a_ext : ~a_ext;
    mix_mag   = a_ext >> MIX_SHIFT;
    mix_term  = noise_bit_c ? mix_mag : ~mix_mag;
    mix_sum   = pulse_val + mix_term;

    // Overflow when the two top bits of the widened sum disagree.
    if (mix_sum[SUM_W-1] != mix_sum[SUM_W-2]) begin
      mix_sat = mix_sum[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      mix_sat = mix_sum[OUT_W-1:0];
    end

    if (sample_c) begin
      out_valid_n   = 1'b1;
      period_done_n = (cnt == last_idx);
      cnt_n         = (cnt == last_idx) ? '0 : cnt + CNT_W'(1);
      if (boundary) begin
        p_n = period;
        m_n = mode;
        a_n = amplitude;
      end
      case (m_eff)
        MODE_SILENT: source_out_n = '0;
        MODE_NOISE:  source_out_n = noise_val[OUT_W-1:0];
        MODE_MIXED:  source_out_n = (p_eff == '0) ? noise_val[OUT_W-1:0] : mix_sat;
        default:     source_out_n = (p_eff == '0) ? noise_val[OUT_W-1:0] : pulse_val[OUT_W-1:0];
      endcase
    end
  end

endmodule

// File: tb/tb_speech_source_gen.sv
// Directed self-checking bench for speech_source_gen (default parameters).
module tb_speech_source_gen;

  logic        clk = 1'b0;
  logic        rst_an = 1'b0;
  logic        strobe = 1'b0;
  logic [7:0]  period = '0;
  logic [14:0] amplitude = '0;
  logic [1:0]  mode = '0;
  logic        period_done, out_valid;
  logic [15:0] source_out;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  logic [16:0] lfsr_m = 17'h1;

  speech_source_gen dut (
    .clk         (clk),
    .rst_an      (rst_an),
    .strobe      (strobe),
    .period      (period),
    .amplitude   (amplitude),
    .mode        (mode),
    .period_done (period_done),
    .out_valid   (out_valid),
    .source_out  (source_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) valid_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Next noise bit from the reference LFSR (x^17+x^3+1).
  function automatic logic next_n();
    logic n;
    n = lfsr_m[16] ^ lfsr_m[2];
    lfsr_m = {lfsr_m[15:0], n};
    return n;
  endfunction

  task automatic take(output int val, output logic done, output logic vld);
    @(negedge clk); strobe = 1'b1;
    @(negedge clk);
    val  = int'($signed(source_out));
    done = period_done;
    vld  = out_valid;
    strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    strobe = 1'b0;
    rst_an = 1'b0;
    #1;
    check("rst_done", int'(period_done), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_out", int'($signed(source_out)), 0);
    @(negedge clk);
    rst_an = 1'b1;
    lfsr_m = 17'h1;
    @(negedge clk);
    check("done_clear", int'(period_done), 0);
  endtask

  initial begin
    int v;
    logic d, vl, n;
    int base;

    // Pulse train, period 10.
    period = 8'd10; mode = 2'd0; amplitude = 15'd1000;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      take(v, d, vl);
      check("pulse_val", v, ((i % 10) < 8) ? 1000 : 0);
      check("pulse_done", int'(d), ((i % 10) == 9) ? 1 : 0);
      check("pulse_vld", int'(vl), 1);
    end

    // Noise at full scale; period input ignored, frame is 64.
    period = 8'd10; mode = 2'd1; amplitude = 15'h7FFF;
    do_reset();
    for (int i = 0; i < 130; i++) begin
      n = next_n();
      take(v, d, vl);
      check("noise_val", v, n ? 32767 : -32768);
      check("noise_done", int'(d), ((i % 64) == 63) ? 1 : 0);
    end

    // Period changes 10->20 mid-period; takes effect at next boundary.
    period = 8'd10; mode = 2'd0; amplitude = 15'd1000;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i == 4) period = 8'd20;
      take(v, d, vl);
      base = (i < 10) ? i : i - 10;
      check("chg_val", v, (base < 8) ? 1000 : 0);
      check("chg_done", int'(d), (i == 9 || i == 29) ? 1 : 0);
    end

    // Mixed mode with saturation.
    period = 8'd10; mode = 2'd2; amplitude = 15'h7FFF;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      n = next_n();
      take(v, d, vl);
      if ((i % 10) < 8) check("mix_pulse", v, n ? 32767 : 24575);
      else              check("mix_gap", v, n ? 8191 : -8192);
      check("mix_done", int'(d), ((i % 10) == 9) ? 1 : 0);
    end

    // Strobe held high yields one sample; then one per toggle.
    base = valid_cnt;
    @(negedge clk); strobe = 1'b1;
    repeat (50) @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    check("hold_count", valid_cnt - base, 1);
    base = valid_cnt;
    for (int i = 0; i < 5; i++) take(v, d, vl);
    @(negedge clk);
    check("toggle_count", valid_cnt - base, 5);

    // Reset mid-period at cnt 5 in mixed mode; restart from cnt 0, reseeded.
    period = 8'd10; mode = 2'd2; amplitude = 15'h7FFF;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n = next_n();
      take(v, d, vl);
      check("pre_rst_val", v, n ? 32767 : 24575);
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      n = next_n();
      take(v, d, vl);
      if ((i % 10) < 8) check("post_rst_pulse", v, n ? 32767 : 24575);
      else              check("post_rst_gap", v, n ? 8191 : -8192);
      check("post_rst_done", int'(d), ((i % 10) == 9) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
